// File: rtl/program_sequencer.sv
// Instruction sequencer driving an external program counter over a small ISA
// (NOP, JMP, WAIT, SETOUT, JMPM, HALT); define SEQ_LOOP_EN for the LDC/DJNZ loop opcodes.
module program_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic        mode_sel,
  input  logic [7:0]  pc_in,
  input  logic [11:0] instr,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [7:0]  pc_reset_val,
  output logic [7:0]  pc_load_val,
  output logic [7:0]  out_reg,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned OP_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_JMP    = 4'h1;
  localparam logic [OP_W-1:0] OP_WAIT   = 4'h2;
  localparam logic [OP_W-1:0] OP_SETOUT = 4'h3;
  localparam logic [OP_W-1:0] OP_JMPM   = 4'h4;
  localparam logic [OP_W-1:0] OP_HALT   = 4'hF;
`ifdef SEQ_LOOP_EN
  localparam logic [OP_W-1:0] OP_LDC    = 4'h5;
  localparam logic [OP_W-1:0] OP_DJNZ   = 4'h6;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t              state, state_nxt;
  logic [INSTR_W-1:0]  ir, ir_nxt;
  logic [DATA_W-1:0]   wait_cnt, wait_nxt;
  logic [DATA_W-1:0]   out_nxt;
  logic [OP_W-1:0]     op;
  logic [DATA_W-1:0]   arg;
  logic                run_req;
  logic                unused_pc;

  // The PC value itself is owned by the external counter; only instr matters here.
  assign unused_pc = ^pc_in;

  assign op           = ir[INSTR_W-1:INSTR_W-OP_W];
  assign arg          = ir[DATA_W-1:0];
  assign pc_reset_val = DATA_W'(0);

  // Keep pc_reset quiet while reset is held, even though the FSM sits in IDLE.
  assign run_req = start & reset;

`ifdef SEQ_LOOP_EN
  logic [DATA_W-1:0] loop_cnt, loop_nxt, loop_dec;

  assign loop_dec = loop_cnt - DATA_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) loop_cnt <= '0;
    else        loop_cnt <= loop_nxt;
  end
`else
  // No loop counter: opcodes 0x5/0x6 decode as NOP through the default arm.
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      out_reg  <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ir       <= ir_nxt;
      wait_cnt <= wait_nxt;
      out_reg  <= out_nxt;
      busy     <= (state_nxt == S_FETCH) || (state_nxt == S_EXEC) || (state_nxt == S_WAIT);
      halted   <= (state_nxt == S_HALT);
    end
  end

  // Next-state, datapath updates and PC control pulses.
  always_comb begin
    state_nxt   = state;
    ir_nxt      = ir;
    wait_nxt    = wait_cnt;
    out_nxt     = out_reg;
    pc_reset    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = '0;
`ifdef SEQ_LOOP_EN
    loop_nxt    = loop_cnt;
`endif

    unique case (state)
      S_IDLE, S_HALT: begin
        if (run_req) begin
          pc_reset  = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_nxt    = instr;
        state_nxt = S_EXEC;
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op)
          OP_JMP: begin
            pc_load     = 1'b1;
            pc_load_val = arg;
          end
          OP_WAIT: begin
            if (arg == '0) begin
              pc_inc = 1'b1;
            end else begin
              wait_nxt  = arg;
              state_nxt = S_WAIT;
            end
          end
          OP_SETOUT: begin
            out_nxt = arg;
            pc_inc  = 1'b1;
          end
          OP_JMPM: begin
            if (mode_sel) begin
              pc_load     = 1'b1;
              pc_load_val = arg;
            end else begin
              pc_inc = 1'b1;
            end
          end
          OP_HALT: begin
            state_nxt = S_HALT;
          end
`ifdef SEQ_LOOP_EN
          OP_LDC: begin
            loop_nxt = arg;
            pc_inc   = 1'b1;
          end
          OP_DJNZ: begin
            loop_nxt = loop_dec;
            if (loop_dec != '0) begin
              pc_load     = 1'b1;
              pc_load_val = arg;
            end else begin
              pc_inc = 1'b1;
            end
          end
`endif
          OP_NOP:  pc_inc = 1'b1;
          default: pc_inc = 1'b1;
        endcase
      end

      // Counter reaching zero means the last tick has been consumed.
      S_WAIT: begin
        if (wait_cnt == '0) begin
          pc_inc    = 1'b1;
          state_nxt = S_FETCH;
        end else if (tick) begin
          wait_nxt = wait_cnt - DATA_W'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: an instruction-level trace model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_program_sequencer;

  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic        mode_sel = 1'b0;
  logic [7:0]  pc_in;
  logic [11:0] instr;
  logic        pc_reset, pc_load, pc_inc;
  logic [7:0]  pc_reset_val, pc_load_val, out_reg;
  logic        busy, halted;

  typedef struct packed {
    logic       r;
    logic       l;
    logic       i;
    logic [7:0] rv;
    logic [7:0] v;
    logic [7:0] o;
    logic       b;
    logic       h;
  } vec_t;

  logic [11:0] rom [256];
  bit          start_a [MAXC];
  bit          tick_a  [MAXC];
  bit          mode_a  [MAXC];
  vec_t        exp_v   [MAXC];
  vec_t        act_v   [MAXC];
  int          vectors = 0;
  int          errors  = 0;
  int          run_id  = 0;

  program_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .mode_sel(mode_sel),
    .pc_in(pc_in), .instr(instr),
    .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_reset_val(pc_reset_val), .pc_load_val(pc_load_val),
    .out_reg(out_reg), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // External program counter and combinational ROM.
  assign instr = rom[pc_in];
  always @(posedge clk or negedge reset) begin
    if (!reset)        pc_in <= 8'd0;
    else if (pc_reset) pc_in <= 8'd0;
    else if (pc_load)  pc_in <= pc_load_val;
    else if (pc_inc)   pc_in <= pc_in + 8'd1;
  end

  function automatic void put(input int c, input bit r, input bit l, input bit i,
                              input int v, input int o, input bit b, input bit h);
    exp_v[c] = '{r: r, l: l, i: i, rv: 8'd0, v: 8'(v), o: 8'(o), b: b, h: h};
  endfunction

  // Interpret the program instruction by instruction, emitting the cycles each one occupies.
  function automatic void build_expect(input int n);
    int c = 0, pc = 0, outv = 0, lc = 0, op, a, rem;
    bit h = 0, run;
    lc = lc;
    while (c < n) begin
      if (!start_a[c]) begin
        put(c, 0, 0, 0, 0, outv, 0, h);
        c++;
      end else begin
        put(c, 1, 0, 0, 0, outv, 0, h);
        c++; pc = 0; h = 0; run = 1;
        while (run && c < n) begin
          put(c, 0, 0, 0, 0, outv, 1, 0);
          op = int'(rom[pc][11:8]);
          a  = int'(rom[pc][7:0]);
          c++;
          if (c >= n) break;
          case (op)
            1: begin put(c, 0, 1, 0, a, outv, 1, 0); pc = a; end
            2: begin
              if (a == 0) begin
                put(c, 0, 0, 1, 0, outv, 1, 0);
              end else begin
                put(c, 0, 0, 0, 0, outv, 1, 0);
                c++;
                rem = a;
                while (rem > 0 && c < n) begin
                  put(c, 0, 0, 0, 0, outv, 1, 0);
                  if (tick_a[c]) rem--;
                  c++;
                end
                if (c < n) put(c, 0, 0, 1, 0, outv, 1, 0);
              end
              pc = (pc + 1) % 256;
            end
            3: begin put(c, 0, 0, 1, 0, outv, 1, 0); outv = a; pc = (pc + 1) % 256; end
            4: begin
              if (mode_a[c]) begin put(c, 0, 1, 0, a, outv, 1, 0); pc = a; end
              else begin put(c, 0, 0, 1, 0, outv, 1, 0); pc = (pc + 1) % 256; end
            end
            15: begin put(c, 0, 0, 0, 0, outv, 1, 0); h = 1; run = 0; end
`ifdef SEQ_LOOP_EN
            5: begin lc = a; put(c, 0, 0, 1, 0, outv, 1, 0); pc = (pc + 1) % 256; end
            6: begin
              lc = (lc + 255) % 256;
              if (lc != 0) begin put(c, 0, 1, 0, a, outv, 1, 0); pc = a; end
              else begin put(c, 0, 0, 1, 0, outv, 1, 0); pc = (pc + 1) % 256; end
            end
`endif
            default: begin put(c, 0, 0, 1, 0, outv, 1, 0); pc = (pc + 1) % 256; end
          endcase
          c++;
        end
      end
    end
  endfunction

  task automatic drive(input int c);
    start    = start_a[c];
    tick     = tick_a[c];
    mode_sel = mode_a[c];
  endtask

  task automatic sample(input int c);
    vec_t a;
    a = '{r: pc_reset, l: pc_load, i: pc_inc, rv: pc_reset_val, v: pc_load_val,
          o: out_reg, b: busy, h: halted};
    act_v[c] = a;
    vectors++;
    if (a !== exp_v[c]) begin
      errors++;
      $display("FAIL trace run %0d cyc %0d: got rst%b ld%b inc%b rv%h lv%h out%h busy%b halt%b, want rst%b ld%b inc%b rv%h lv%h out%h busy%b halt%b",
               run_id, c, a.r, a.l, a.i, a.rv, a.v, a.o, a.b, a.h,
               exp_v[c].r, exp_v[c].l, exp_v[c].i, exp_v[c].rv, exp_v[c].v, exp_v[c].o, exp_v[c].b, exp_v[c].h);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      start_a[k] = 0; tick_a[k] = 0; mode_a[k] = 0;
    end
    for (int k = 0; k < 256; k++) rom[k] = 12'h000;
  endtask

  task automatic run_prog(input int n);
    build_expect(n);
    reset = 1'b0; start = 1'b0; tick = 1'b0; mode_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive(0);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      sample(c);
      @(posedge clk);
      #1;
      if (c + 1 < n) drive(c + 1);
      else begin start = 1'b0; tick = 1'b0; end
    end
    run_id++;
  endtask

  function automatic int count_pulses(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += int'(act_v[k].r) + int'(act_v[k].l) + int'(act_v[k].i);
    return s;
  endfunction

  initial begin
    int nl, ni;

    // SETOUT 0xC8 then JMP 0, looping.
    clear_stim();
    rom[0] = 12'h3C8; rom[1] = 12'h100;
    start_a[0] = 1;
    run_prog(20);
    check_lit("start_pc_reset", int'(act_v[0].r), 1);
    check_lit("fetch_busy", int'(act_v[1].b), 1);
    check_lit("fetch_quiet", count_pulses(1, 1), 0);
    check_lit("setout_inc_c2", int'(act_v[2].i), 1);
    check_lit("out_reg_200", int'(act_v[3].o), 200);
    check_lit("jmp_load_c4", int'(act_v[4].l), 1);
    check_lit("jmp_val_c4", int'(act_v[4].v), 0);
    check_lit("jmp_repeat_c8", int'(act_v[8].l), 1);

    // WAIT 3 with a tick every 10 cycles, then HALT.
    clear_stim();
    rom[0] = 12'h203; rom[1] = 12'hF00;
    start_a[0] = 1;
    tick_a[5] = 1; tick_a[15] = 1; tick_a[25] = 1; tick_a[35] = 1;
    run_prog(40);
    check_lit("wait_quiet", count_pulses(2, 25), 0);
    check_lit("wait_inc_after_tick3", int'(act_v[26].i), 1);
    check_lit("halted_after_halt", int'(act_v[30].h), 1);
    check_lit("halt_quiet", count_pulses(27, 39), 0);

    // JMPM taken and not taken, HALT, restart.
    clear_stim();
    rom[0] = 12'h420; rom[8'h20] = 12'h400; rom[8'h21] = 12'hF00;
    start_a[0] = 1; start_a[3] = 1; start_a[12] = 1;
    mode_a[2] = 1; mode_a[4] = 0;
    run_prog(20);
    check_lit("jmpm_load", int'(act_v[2].l), 1);
    check_lit("jmpm_val", int'(act_v[2].v), 32);
    check_lit("jmpm_inc", int'(act_v[4].i), 1);
    check_lit("halt_restart_reset", int'(act_v[12].r), 1);

    // Loop opcodes: LDC 3, NOP, DJNZ 1.
    clear_stim();
    rom[0] = 12'h503; rom[1] = 12'h000; rom[2] = 12'h601; rom[3] = 12'hF00;
    start_a[0] = 1;
    run_prog(24);
    nl = 0; ni = 0;
    for (int k = 0; k < 24; k++) begin nl += int'(act_v[k].l); ni += int'(act_v[k].i); end
`ifdef SEQ_LOOP_EN
    check_lit("djnz_loads", nl, 2);
    check_lit("djnz_incs", ni, 5);
`else
    check_lit("loopop_loads", nl, 0);
    check_lit("loopop_incs", ni, 3);
`endif

    // Randomized programs and stimulus.
    for (int r = 0; r < 8; r++) begin
      clear_stim();
      for (int k = 0; k < 256; k++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'h2) rom[k] = {op, 8'($urandom_range(0, 3))};
        else            rom[k] = {op, 8'($urandom)};
      end
      for (int k = 0; k < 300; k++) begin
        start_a[k] = ($urandom_range(0, 3) == 0);
        tick_a[k]  = ($urandom_range(0, 2) == 0);
        mode_a[k]  = $urandom_range(0, 1) != 0;
      end
      run_prog(300);
    end

    // Reset asserted in the middle of a WAIT.
    clear_stim();
    rom[0] = 12'h355; rom[1] = 12'h2C8;
    start_a[0] = 1;
    run_prog(10);
    check_lit("out_before_reset", int'(act_v[5].o), 85);
    check_lit("busy_in_wait", int'(act_v[9].b), 1);
    #2 reset = 1'b0;
    start = 1'b1;
    #1;
    check_lit("rst_out_reg", int'(out_reg), 0);
    check_lit("rst_busy_halted", int'(busy) + int'(halted), 0);
    check_lit("rst_pulses", int'(pc_reset) + int'(pc_load) + int'(pc_inc), 0);
    @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_lit("idle_after_reset", int'(pc_reset) + int'(pc_load) + int'(pc_inc) + int'(busy), 0);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
